// File: rtl/sram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sram_rr_arbiter
//
// Shares one single-port synchronous SRAM macro between two requesters.
// The requesters take turns by round-robin. Only one access is in flight at
// a time. Each request uses a valid/ready handshake. Each completion is
// reported with a single-cycle rsp_valid pulse to the requester that owns it.
//
// Access sequence, where T is the IDLE cycle in which the handshake happens:
//   T    IDLE  req_ready[g] = 1. The command and owner are latched at the edge.
//   T+1  ACC   mem_en = 1 and the latched command is presented to the SRAM.
//   T+2  RD    (reads only) mem_rdata is captured.
//   T+2  RSP   (writes) or T+3 (reads): rsp_valid[owner] pulses for one cycle.
//
// Parameters
//   ADDR_W     SRAM address width (depth = 2**ADDR_W)
//   DATA_W     SRAM data width
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid
//   req_we     per-requester write enable (1 = write, 0 = read)
//   req_addr   requester i address at [i*ADDR_W +: ADDR_W]
//   req_wdata  requester i write data at [i*DATA_W +: DATA_W]
//   req_ready  accept strobe, one-hot or zero, combinational, IDLE only
//   rsp_valid  one-cycle completion pulse to the owning requester
//   rsp_rdata  read data qualified by rsp_valid, zero otherwise and for writes
//   mem_en     SRAM enable (registered)
//   mem_we     SRAM write enable (registered)
//   mem_addr   SRAM address (registered)
//   mem_wdata  SRAM write data (registered)
//   mem_rdata  SRAM read data, valid one cycle after a read enable
//   busy       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module sram_rr_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StRd,
        StRsp
    } state_e;

    state_e state_q, state_d;

    // Arbitration state and latched command
    logic              ptr_q;       // requester favoured on the next tie
    logic              owner_q;     // requester that owns the access in flight
    logic              cmd_we_q;    // kept past ACC so RSP knows read vs write
    logic [DATA_W-1:0] rdata_q;

    // Registered SRAM interface
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Grant decode
    logic              accept;
    logic              grant;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    // Muxing on the one-bit grant keeps the slices constant-width.
    always_comb begin
        grant_we    = grant ? req_we[1] : req_we[0];
        grant_addr  = grant ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
        grant_wdata = grant ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    end

    // Next-state logic and handshake
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        grant     = 1'b0;
        req_ready = 2'b00;

        case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    // The favoured requester wins if it is asking; otherwise the other one must be.
                    grant            = req_valid[ptr_q] ? ptr_q : ~ptr_q;
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_d          = StAcc;
                end
            end
            StAcc:   state_d = cmd_we_q ? StRsp : StRd;
            StRd:    state_d = StRsp;
            StRsp:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Response outputs are decoded from state so that they are zero outside RSP.
    always_comb begin
        rsp_valid = 2'b00;
        rsp_rdata = '0;
        if (state_q == StRsp) begin
            rsp_valid[owner_q] = 1'b1;
            if (!cmd_we_q) begin
                rsp_rdata = rdata_q;
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            cmd_we_q    <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            // The enable is high only in ACC, the cycle after a handshake.
            mem_en_q <= accept;

            if (accept) begin
                owner_q     <= grant;
                ptr_q       <= ~grant;
                cmd_we_q    <= grant_we;
                mem_we_q    <= grant_we;
                mem_addr_q  <= grant_addr;
                mem_wdata_q <= grant_wdata;
            end else if (state_q == StAcc) begin
                // Drop the write enable together with the enable. Address and data may stay.
                mem_we_q <= 1'b0;
            end

            if (state_q == StRd) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule
